// File: rtl/ace_read_arbiter.sv
// ACE read-channel arbiter: round-robin sharing of one AR/R port between
// instruction fetch (requester 0) and the LSU (requester 1), R steered back by RID.
module ace_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_arvalid,
  output logic [1:0]              req_arready,
  input  logic [2*ADDR_WIDTH-1:0] req_araddr,
  input  logic [15:0]             req_arlen,
  input  logic [5:0]              req_arsize,
  output logic [1:0]              req_rvalid,
  input  logic [1:0]              req_rready,
  output logic [DATA_WIDTH-1:0]   req_rdata,
  output logic [3:0]              req_rresp,
  output logic                    req_rlast,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [3:0]              m_rresp,
  input  logic                    m_rlast,
  output logic                    err_rid
);

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic {IDLE, ADDR} state_t;

  state_t                state;
  logic                  grant;
  logic                  rr_last;
  logic [1:0]            outstanding;
  logic [1:0]            outstanding_nxt;
  logic [1:0]            eligible;
  logic                  pick;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [7:0]            pick_len;
  logic [2:0]            pick_size;
  logic                  ar_done;
  logic                  r_idx;
  logic                  r_matched;
  logic                  r_last_done;

  assign eligible = req_arvalid & ~outstanding;

  // A lone eligible requester wins; a tie goes to the one not served last.
  always_comb begin
    pick = 1'b0;
    case (eligible)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~rr_last;
      default: pick = 1'b0;
    endcase
  end

  always_comb begin
    pick_addr = req_araddr[0 +: ADDR_WIDTH];
    pick_len  = req_arlen[7:0];
    pick_size = req_arsize[2:0];
    if (pick) begin
      pick_addr = req_araddr[ADDR_WIDTH +: ADDR_WIDTH];
      pick_len  = req_arlen[15:8];
      pick_size = req_arsize[5:3];
    end
  end

  assign ar_done     = (state == ADDR) && m_arready;
  assign req_arready = {ar_done && grant, ar_done && !grant};

  // Only IDs 0/1 with clear upper bits can match; anything else is drained and flagged.
  assign r_idx     = m_rid[0];
  assign r_matched = ((m_rid >> 1) == '0) && outstanding[r_idx];

  assign req_rvalid  = r_matched ? {m_rvalid && r_idx, m_rvalid && !r_idx} : 2'b00;
  assign m_rready    = r_matched ? req_rready[r_idx] : 1'b1;
  assign req_rdata   = m_rdata;
  assign req_rresp   = m_rresp;
  assign req_rlast   = m_rlast;
  assign r_last_done = m_rvalid && m_rready && m_rlast && r_matched;

  // A last beat for one requester and an AR accept for the other may land together.
  always_comb begin
    outstanding_nxt = outstanding;
    if (r_last_done) outstanding_nxt[r_idx] = 1'b0;
    if (ar_done)     outstanding_nxt[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      rr_last     <= 1'b1;
      outstanding <= 2'b00;
      err_rid     <= 1'b0;
      m_arvalid   <= 1'b0;
      m_arid      <= '0;
      m_araddr    <= '0;
      m_arlen     <= '0;
      m_arsize    <= '0;
      m_arburst   <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (m_rvalid && !r_matched) err_rid <= 1'b1;
      case (state)
        IDLE: begin
          if (|eligible) begin
            state     <= ADDR;
            grant     <= pick;
            m_arvalid <= 1'b1;
            m_arid    <= ID_WIDTH'(pick);
            m_araddr  <= pick_addr;
            m_arlen   <= pick_len;
            m_arsize  <= pick_size;
            m_arburst <= BURST_INCR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            state     <= IDLE;
            rr_last   <= grant;
            m_arvalid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ace_read_arbiter.sv
// Scoreboard bench for ace_read_arbiter: random requesters and a random R master,
// checked against a transaction-level reference of the arbitration and routing rules.
module tb_ace_read_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  resp;
    logic        last;
  } r_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_arvalid, req_arready;
  logic [2*AW-1:0] req_araddr;
  logic [15:0]   req_arlen;
  logic [5:0]    req_arsize;
  logic [1:0]    req_rvalid, req_rready;
  logic [DW-1:0] req_rdata;
  logic [3:0]    req_rresp;
  logic          req_rlast;
  logic          m_arvalid, m_arready;
  logic [IW-1:0] m_arid;
  logic [AW-1:0] m_araddr;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_rvalid, m_rready;
  logic [IW-1:0] m_rid;
  logic [DW-1:0] m_rdata;
  logic [3:0]    m_rresp;
  logic          m_rlast;
  logic          err_rid;

  always #5 clk = ~clk;

  ace_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_araddr(req_araddr),
    .req_arlen(req_arlen), .req_arsize(req_arsize),
    .req_rvalid(req_rvalid), .req_rready(req_rready), .req_rdata(req_rdata),
    .req_rresp(req_rresp), .req_rlast(req_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .err_rid(err_rid)
  );

  ar_t exp_ar0[$], exp_ar1[$];
  r_t  exp_r0[$],  exp_r1[$];

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  done = 1'b0;
  bit  drain_to = 1'b0;

  // Stimulus-side state
  int  beats_left[2];
  bit  abandoned[2];
  int  cur_rid;
  bit  inj;
  int  mar_mode;
  bit  r_en;
  bit  allow_new;
  int  p_issue;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int i, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
    ar_t a;
    a.addr = addr; a.len = len; a.size = size;
    req_arvalid[i] = 1'b1;
    req_araddr[i*AW +: AW] = addr;
    req_arlen[i*8 +: 8] = len;
    req_arsize[i*3 +: 3] = size;
    if (i == 0) exp_ar0.push_back(a); else exp_ar1.push_back(a);
  endtask

  task automatic send_beat();
    int id;
    r_t b;
    if (beats_left[0] == 0 && beats_left[1] == 0) return;
    if (beats_left[0] != 0 && beats_left[1] != 0) id = int'($urandom_range(0, 1));
    else id = (beats_left[1] != 0) ? 1 : 0;
    b.data = $urandom;
    b.resp = 4'($urandom_range(0, 15));
    b.last = (beats_left[id] == 1);
    m_rvalid = 1'b1; m_rid = IW'(id); m_rdata = b.data; m_rresp = b.resp; m_rlast = b.last;
    cur_rid = id;
    if (!abandoned[id]) begin
      if (id == 0) exp_r0.push_back(b); else exp_r1.push_back(b);
    end
  endtask

  // One clock: observe handshakes mid-cycle, then update stimulus just after the edge.
  task automatic step();
    logic [1:0]    arr;
    logic          mhs, rhs, rst_s;
    logic [IW-1:0] mid;
    logic [7:0]    mlen;
    @(negedge clk);
    arr = req_arready; mhs = m_arvalid && m_arready; mid = m_arid; mlen = m_arlen;
    rhs = m_rvalid && m_rready; rst_s = rst;
    @(posedge clk); #1;
    if (!rst_s) begin
      for (int i = 0; i < 2; i++) if (arr[i]) req_arvalid[i] = 1'b0;
      if (mhs) beats_left[mid] = int'(mlen) + 1;
      if (rhs) begin
        if (inj) inj = 1'b0;
        else begin
          beats_left[cur_rid]--;
          if (beats_left[cur_rid] == 0) abandoned[cur_rid] = 1'b0;
        end
        m_rvalid = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++)
      if (allow_new && !req_arvalid[i] && $urandom_range(0, 99) < p_issue)
        issue(i, $urandom, 8'($urandom_range(0, 3)), 3'($urandom_range(0, 2)));
    req_rready[0] = ($urandom_range(0, 3) != 0);
    req_rready[1] = ($urandom_range(0, 3) != 0);
    case (mar_mode)
      1:       m_arready = 1'b0;
      2:       m_arready = 1'b1;
      default: m_arready = ($urandom_range(0, 9) < 7);
    endcase
    if (r_en && !m_rvalid && $urandom_range(0, 2) != 0) send_beat();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((req_arvalid != 2'b00 || beats_left[0] != 0 || beats_left[1] != 0 || m_rvalid) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) drain_to = 1'b1;
  endtask

  initial begin : stimulus
    rst = 1'b1;
    req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_arsize = '0; req_rready = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    beats_left[0] = 0; beats_left[1] = 0; abandoned[0] = 1'b0; abandoned[1] = 1'b0;
    cur_rid = 0; inj = 1'b0; mar_mode = 2; r_en = 1'b1; allow_new = 1'b0; p_issue = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch, then two ties in a row
    issue(0, 32'h8000_0000, 8'd0, 3'd2);
    repeat (8) step();
    issue(0, 32'h0000_1000, 8'd1, 3'd2); issue(1, 32'h0000_2000, 8'd0, 3'd2);
    repeat (14) step();
    drain(200);
    issue(0, 32'h0000_3000, 8'd0, 3'd2); issue(1, 32'h0000_4000, 8'd2, 3'd1);
    repeat (14) step();
    drain(200);

    // Address backpressure with requester 1 presented and requester 0 waiting
    mar_mode = 1;
    issue(1, 32'hCAFE_0000, 8'd1, 3'd2);
    step();
    issue(0, 32'hBEEF_0000, 8'd0, 3'd2);
    repeat (6) step();
    mar_mode = 2;
    drain(200);

    // Requester 0 re-requests while its burst is still outstanding
    r_en = 1'b0;
    issue(0, 32'h1111_0000, 8'd3, 3'd2);
    repeat (3) step();
    issue(0, 32'h2222_0000, 8'd0, 3'd2); issue(1, 32'h3333_0000, 8'd1, 3'd2);
    repeat (6) step();
    r_en = 1'b1;
    drain(300);

    // Random traffic
    mar_mode = 0; allow_new = 1'b1; p_issue = 30;
    repeat (2500) step();
    allow_new = 1'b0;
    drain(500);

    // Unmatched beat with nothing outstanding
    r_en = 1'b0;
    m_rvalid = 1'b1; m_rid = IW'(1); m_rdata = 32'hDEAD_BEEF; m_rresp = 4'h0; m_rlast = 1'b1; inj = 1'b1;
    repeat (4) step();
    r_en = 1'b1; allow_new = 1'b1;
    repeat (200) step();
    allow_new = 1'b0;
    drain(500);

    // Reset while an address is presented and a burst is outstanding
    mar_mode = 2; r_en = 1'b0;
    issue(1, 32'h4444_0000, 8'd3, 3'd2);
    repeat (3) step();
    mar_mode = 1;
    issue(0, 32'h5555_0000, 8'd0, 3'd2);
    repeat (3) step();
    rst = 1'b1; req_arvalid = '0; m_rvalid = 1'b0; inj = 1'b0;
    exp_ar0.delete(); exp_ar1.delete(); exp_r0.delete(); exp_r1.delete();
    for (int i = 0; i < 2; i++) abandoned[i] = (beats_left[i] != 0);
    step();
    rst = 1'b0; mar_mode = 2; r_en = 1'b1;
    drain(200);
    issue(0, 32'h6666_0000, 8'd1, 3'd2);
    drain(200);
    repeat (3) step();
    done = 1'b1;
  end

  initial begin : monitor
    logic [1:0] ref_out, out_n, elig, exp_rv;
    bit busy, busy_n, cur, last_winner, ref_err, err_n, prev_rst, idx, matched;
    ar_t ea;
    r_t  er;
    ref_out = '0; busy = 1'b0; cur = 1'b0; last_winner = 1'b1; ref_err = 1'b0; prev_rst = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (!done) begin
        if (rst) begin
          ref_out = '0; busy = 1'b0; last_winner = 1'b1; ref_err = 1'b0; prev_rst = 1'b1;
        end else begin
          if (prev_rst) begin
            check("rst_arvalid", 64'(m_arvalid), 64'(0));
            check("rst_arid",    64'(m_arid),    64'(0));
            check("rst_araddr",  64'(m_araddr),  64'(0));
            check("rst_arlen",   64'(m_arlen),   64'(0));
            check("rst_arsize",  64'(m_arsize),  64'(0));
            check("rst_arburst", 64'(m_arburst), 64'(0));
            prev_rst = 1'b0;
          end
          out_n = ref_out; busy_n = busy; err_n = ref_err;
          check("err_rid", 64'(err_rid), 64'(ref_err));

          if (busy) begin
            check("arvalid", 64'(m_arvalid), 64'(1));
            check("arid",    64'(m_arid),    64'(cur));
            check("arburst", 64'(m_arburst), 64'(2'b01));
            check("arready", 64'(req_arready), 64'(m_arready ? (cur ? 2'b10 : 2'b01) : 2'b00));
            check("ar_expected", 64'(cur ? exp_ar1.size() : exp_ar0.size()) != 64'(0) ? 64'(1) : 64'(0), 64'(1));
            if ((cur ? exp_ar1.size() : exp_ar0.size()) != 0) begin
              ea = cur ? exp_ar1[0] : exp_ar0[0];
              check("araddr", 64'(m_araddr), 64'(ea.addr));
              check("arlen",  64'(m_arlen),  64'(ea.len));
              check("arsize", 64'(m_arsize), 64'(ea.size));
              if (m_arready) begin
                if (cur) void'(exp_ar1.pop_front()); else void'(exp_ar0.pop_front());
              end
            end
            if (m_arready) begin
              out_n[cur] = 1'b1; last_winner = cur; busy_n = 1'b0;
            end
          end else begin
            check("arvalid_idle", 64'(m_arvalid), 64'(0));
            check("arready_idle", 64'(req_arready), 64'(0));
            elig = req_arvalid & ~ref_out;
            if (elig != 2'b00) begin
              cur = (elig == 2'b11) ? !last_winner : elig[1];
              busy_n = 1'b1;
            end
          end

          if (m_rvalid) begin
            idx = m_rid[0]; matched = ref_out[idx];
            exp_rv = matched ? (idx ? 2'b10 : 2'b01) : 2'b00;
            check("rvalid",  64'(req_rvalid), 64'(exp_rv));
            check("m_rready", 64'(m_rready), 64'(matched ? req_rready[idx] : 1'b1));
            if (!matched) err_n = 1'b1;
            else if (req_rready[idx]) begin
              check("r_expected", (idx ? exp_r1.size() : exp_r0.size()) != 0 ? 64'(1) : 64'(0), 64'(1));
              if ((idx ? exp_r1.size() : exp_r0.size()) != 0) begin
                er = idx ? exp_r1.pop_front() : exp_r0.pop_front();
                check("rdata", 64'(req_rdata), 64'(er.data));
                check("rresp", 64'(req_rresp), 64'(er.resp));
                check("rlast", 64'(req_rlast), 64'(er.last));
                if (er.last) out_n[idx] = 1'b0;
              end
            end
          end else begin
            check("rvalid_idle", 64'(req_rvalid), 64'(0));
          end

          ref_out = out_n; busy = busy_n; ref_err = err_n;
        end
      end
    end
    check("drain_timeout", 64'(drain_to), 64'(0));
    check("ar0_left", 64'(exp_ar0.size()), 64'(0));
    check("ar1_left", 64'(exp_ar1.size()), 64'(0));
    check("r0_left",  64'(exp_r0.size()),  64'(0));
    check("r1_left",  64'(exp_r1.size()),  64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ace_read_arbiter.md
Name: ace_read_arbiter

Overview:
- Shares the single ACE read channel pair (AR/R) between two requesters: requester 0 = instruction fetch, requester 1 = LSU.
- Round-robin arbitration of AR requests; ARID carries the requester index; R beats are routed back by RID.
- Sits between the IF/LSU stages and the cache/interconnect master port.
- At most one outstanding read per requester.

Parameters:
ADDR_WIDTH, 32 (XLEN), address width
DATA_WIDTH, 32, R data width
ID_WIDTH, 1 (ACE_XID_WIDTH), ARID/RID width; must be at least 1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_arvalid  in  2  per-requester AR valid, bit i = requester i
req_arready  out  2  per-requester AR ready
req_araddr  in  2*ADDR_WIDTH  per-requester address, requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_arlen  in  2*8  per-requester burst length
req_arsize  in  2*3  per-requester beat size
req_rvalid  out  2  per-requester R valid
req_rready  in  2  per-requester R ready
req_rdata  out  DATA_WIDTH  R data, broadcast to both requesters
req_rresp  out  4  R resp, broadcast
req_rlast  out  1  R last, broadcast
m_arvalid  out  1  master AR valid
m_arready  in  1  master AR ready
m_arid  out  ID_WIDTH  requester index, zero-extended
m_araddr  out  ADDR_WIDTH  master address
m_arlen  out  8  master burst length
m_arsize  out  3  master beat size
m_arburst  out  2  constant 2'b01 (INCR)
m_rvalid  in  1  master R valid
m_rready  out  1  master R ready
m_rid  in  ID_WIDTH  master R id
m_rdata  in  DATA_WIDTH  master R data
m_rresp  in  4  master R resp
m_rlast  in  1  master R last
err_rid  out  1  sticky flag: R beat seen with no matching outstanding read

Behaviour:
State
- FSM {IDLE, ADDR}.
- grant (1 bit) and rr_last (1 bit): last requester that completed an AR handshake.
- outstanding[1:0].

Arbitration
- Requester i is eligible when req_arvalid[i] && !outstanding[i].
- IDLE: if neither requester is eligible, stay in IDLE.
- IDLE: if exactly one is eligible, grant it.
- IDLE: if both are eligible, grant !rr_last.
- On any grant, register the requester's addr/len/size into the m_ar* registers and go to ADDR.
- ADDR: m_arvalid=1; grant and all m_ar* outputs are stable until the handshake.
- ADDR: on m_arready, set outstanding[grant], set rr_last=grant, pulse req_arready[grant] for that same cycle, return to IDLE.
- Cost: one idle cycle between consecutive grants (IDLE → ADDR → IDLE).

AR handshake rules
- Requester-side AR handshake completes only in the cycle req_arready[i] pulses.
- Requesters hold arvalid and payload stable until that pulse.
- Requester-side AR latency is at least 2 cycles from req_arvalid to req_arready.
- A requester with outstanding[i]=1 is never granted. Its arvalid may stay high and is serviced after the clear.

R routing
- idx = m_rid[0]. Upper m_rid bits must be zero; nonzero upper bits are treated as unmatched.
- Matched beat (outstanding[idx]=1): req_rvalid[idx]=m_rvalid, m_rready=req_rready[idx], other req_rvalid bit = 0. Combinational, zero latency.
- Unmatched beat: m_rready=1 (beat is drained), no req_rvalid asserted, err_rid set.
- On m_rvalid && m_rready && m_rlast for a matched beat, clear outstanding[idx].
- Simultaneous R-last for requester i and AR handshake for requester j≠i in the same cycle are both applied.
- R-last and a new grant for the same requester cannot occur in the same cycle, because eligibility uses the registered outstanding bit.

Reset
- Synchronous, overrides everything.
- After reset: state=IDLE, grant=0, rr_last=1 (so requester 0 wins the first tie), outstanding=0, err_rid=0.
- All m_ar* outputs = 0, m_arvalid=0, req_arready=0.
- Reset mid-burst abandons the in-flight transactions; any R beats arriving afterwards are unmatched and drained with err_rid set.

Test Plan:
- Single fetch: req_arvalid=01, addr 0x8000_0000, len 0; m_arready=1 → m_arvalid high in cycle 1 with m_arid=0 and m_arburst=01; req_arready[0] pulses in cycle 1; an R beat with RID=0 and rlast=1 is delivered on req_rvalid[0] and clears outstanding[0].
- Tie after reset: both arvalid from cycle 0 → requester 0 granted first, then requester 1 (ARID 0 then 1, a 1-cycle IDLE gap between them). Repeat the tie after both complete → grant order 0, 1 again, because rr_last=1 after the second grant.
- Backpressure: m_arready held low for 5 cycles while requester 1 is in ADDR → m_araddr/m_arid stay stable and requester 0 is not granted; requester 1 is granted when m_arready rises.
- Outstanding block: requester 0 burst len=3 in flight; requester 0 re-asserts arvalid → no grant until the 4th beat with rlast; requester 1 is granted meanwhile. Interleaved R beats with RID=1/RID=0 are routed to the correct req_rvalid bit, and req_rready low stalls m_rready.
- Unmatched RID: RID=1 beat arrives with outstanding=00 → m_rready=1, req_rvalid=00, err_rid=1 and stays set until rst.
- Reset mid-operation: assert rst while ADDR is active and a read is outstanding → next cycle m_arvalid=0, outstanding=00, err_rid=0; a fresh request afterwards completes normally.
